// File: rtl/fft_acc_nios2_gen2_0_cpu_ocimem_arbiter_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the OCI memory arbiter: FSM states, jdo field
// positions and default widths.
package fft_acc_nios2_gen2_0_cpu_ocimem_pkg;

    // Default OCI RAM geometry (256 x 32-bit words).
    localparam int OCIMEM_ADDR_W = 8;
    localparam int OCIMEM_DATA_W = 32;

    // Width of the JTAG debug slave data-out bus.
    localparam int JDO_W = 38;

    // Field positions inside jdo.
    localparam int JDO_RD_BIT    = 17;
    localparam int JDO_ADDR_LSB  = 18;
    localparam int JDO_WDATA_LSB = 3;

    // Access sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        JRD  = 2'd1,
        CRD  = 2'd2
    } ocimem_state_e;

    // A command pulse selects read mode when the read bit is set.
    function automatic logic jdo_is_read(input logic [JDO_W-1:0] j);
        return j[JDO_RD_BIT];
    endfunction

endpackage

// File: rtl/fft_acc_nios2_gen2_0_cpu_ocimem_arbiter_if.sv
`timescale 1ns/1ps
// CPU debug-mode data port towards the OCI memory arbiter.
// The CPU side is the master (holds a request until granted); the
// arbiter is the slave (returns a one-cycle grant and read data).
interface fft_acc_nios2_gen2_0_cpu_ocimem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_write;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;

    modport master (
        output cpu_req,
        output cpu_write,
        output cpu_addr,
        output cpu_wdata,
        input  cpu_gnt,
        input  cpu_rdata,
        input  cpu_rvalid
    );

    modport slave (
        input  cpu_req,
        input  cpu_write,
        input  cpu_addr,
        input  cpu_wdata,
        output cpu_gnt,
        output cpu_rdata,
        output cpu_rvalid
    );
endinterface

// File: rtl/fft_acc_nios2_gen2_0_cpu_ocimem_arbiter_rr_arb.sv
`timescale 1ns/1ps
// Two-way round-robin arbiter between the JTAG pending slot and the CPU.
// The fairness bit only moves on a genuine tie, so the loser of one tie
// is guaranteed to win the next one regardless of uncontended grants
// in between.
module fft_acc_nios2_gen2_0_cpu_ocimem_rr_arb (
    input  logic clk,
    input  logic reset_n,
    input  logic req_jtag,
    input  logic req_cpu,
    output logic gnt_jtag,
    output logic gnt_cpu
);

    // 1 when JTAG won the most recent tie; 0 out of reset so JTAG wins first.
    logic last_jtag;
    logic tie;

    // Combinational grant: sole requester wins, ties go to the previous loser.
    always_comb begin
        tie      = req_jtag & req_cpu;
        gnt_jtag = req_jtag & (~req_cpu | ~last_jtag);
        gnt_cpu  = req_cpu  & (~req_jtag | last_jtag);
    end

    // Remember the winner of each tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_jtag <= 1'b0;
        end else if (tie) begin
            last_jtag <= gnt_jtag;
        end
    end

endmodule

// File: rtl/fft_acc_nios2_gen2_0_cpu_ocimem_arbiter.sv
`timescale 1ns/1ps
// OCI debug RAM arbiter: turns JTAG debug slave pulses into RAM accesses
// through a one-entry pending slot, shares the single RAM port with the
// CPU debug-mode data port, and reports JTAG read data and status.
//
// Grants are decided at a clock edge and held in registers for the
// following cycle, which is the issue cycle; the RAM port is driven
// combinationally from those grant registers. A JTAG pulse sampled at an
// edge can therefore be issued in the very next cycle.
module fft_acc_nios2_gen2_0_cpu_ocimem_arbiter
    import fft_acc_nios2_gen2_0_cpu_ocimem_pkg::*;
#(
    parameter int ADDR_W = OCIMEM_ADDR_W,
    parameter int DATA_W = OCIMEM_DATA_W
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 take_action_ocimem_a,
    input  logic                 take_action_ocimem_b,
    input  logic                 take_no_action_ocimem_a,
    input  logic [JDO_W-1:0]     jdo,
    fft_acc_nios2_gen2_0_cpu_ocimem_arbiter_if.slave cpu,
    output logic                 ram_en,
    output logic                 ram_we,
    output logic [ADDR_W-1:0]    ram_addr,
    output logic [DATA_W-1:0]    ram_wdata,
    input  logic [DATA_W-1:0]    ram_rdata,
    output logic [DATA_W-1:0]    MonDReg,
    output logic                 monitor_ready,
    output logic                 monitor_error
);

    ocimem_state_e state;
    ocimem_state_e state_nxt;

    // Registered grants: high during the issue cycle.
    logic gnt_jtag_q;
    logic gnt_cpu_q;

    // CPU read return registers.
    logic              cpu_rvalid_q;
    logic [DATA_W-1:0] cpu_rdata_q;

    // JTAG pending slot and pointer.
    logic              slot_valid;
    logic              slot_we;
    logic [ADDR_W-1:0] slot_addr;
    logic [DATA_W-1:0] slot_wdata;
    logic [ADDR_W-1:0] jaddr;
    logic              jmode_rd;

    // jdo fields.
    logic [ADDR_W-1:0] jdo_addr;
    logic [DATA_W-1:0] jdo_wdata;
    logic              jdo_rd;

    // The remaining jdo bits belong to other debug-slave commands.
    logic unused_jdo;

    // Next-state terms for the slot.
    logic              slot_free;
    logic              accept_a;
    logic              accept_b;
    logic              rearm;
    logic              drop;
    logic [ADDR_W-1:0] jaddr_step;
    logic [ADDR_W-1:0] jaddr_nxt;
    logic              jmode_rd_nxt;
    logic              slot_valid_nxt;
    logic              slot_we_nxt;
    logic [ADDR_W-1:0] slot_addr_nxt;
    logic [DATA_W-1:0] slot_wdata_nxt;

    // Arbiter hookup.
    logic can_issue;
    logic arb_req_jtag;
    logic arb_req_cpu;
    logic arb_gnt_jtag;
    logic arb_gnt_cpu;

    assign jdo_addr   = jdo[JDO_ADDR_LSB +: ADDR_W];
    assign jdo_wdata  = jdo[JDO_WDATA_LSB +: DATA_W];
    assign jdo_rd     = jdo_is_read(jdo);
    assign unused_jdo = ^jdo;

    assign cpu.cpu_gnt    = gnt_cpu_q;
    assign cpu.cpu_rvalid = cpu_rvalid_q;
    assign cpu.cpu_rdata  = cpu_rdata_q;

    // Slot bookkeeping: accept, drop, pointer advance and re-arm.
    always_comb begin
        // The slot can take a new entry if empty or being issued right now.
        slot_free  = ~slot_valid | gnt_jtag_q;
        accept_a   = take_action_ocimem_a & slot_free;
        accept_b   = take_action_ocimem_b & ~take_action_ocimem_a & slot_free;
        rearm      = take_no_action_ocimem_a & ~take_action_ocimem_a & slot_free;
        drop       = (take_action_ocimem_a | take_action_ocimem_b) & ~slot_free;

        // Pointer moves past every issued JTAG access, wrapping naturally.
        jaddr_step = gnt_jtag_q ? (jaddr + ADDR_W'(1)) : jaddr;

        jaddr_nxt      = jaddr_step;
        jmode_rd_nxt   = jmode_rd;
        slot_valid_nxt = slot_valid & ~gnt_jtag_q;
        slot_we_nxt    = slot_we;
        slot_addr_nxt  = slot_addr;
        slot_wdata_nxt = slot_wdata;

        if (accept_a) begin
            // New command: load pointer and mode; read mode fetches at once.
            jaddr_nxt      = jdo_addr;
            jmode_rd_nxt   = jdo_rd;
            slot_valid_nxt = jdo_rd;
            slot_we_nxt    = 1'b0;
            slot_addr_nxt  = jdo_addr;
        end else if (accept_b) begin
            // Data pulse: write the payload or read the next word.
            slot_valid_nxt = 1'b1;
            slot_we_nxt    = ~jmode_rd;
            slot_addr_nxt  = jaddr_step;
            slot_wdata_nxt = jdo_wdata;
        end else if (rearm) begin
            jaddr_nxt    = jdo_addr;
            jmode_rd_nxt = 1'b1;
        end
    end

    // Sequencer next state and arbitration for the next issue cycle.
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE: begin
                if (gnt_jtag_q && !slot_we) begin
                    state_nxt = JRD;
                end else if (gnt_cpu_q && !cpu.cpu_write) begin
                    state_nxt = CRD;
                end else begin
                    state_nxt = IDLE;
                end
            end
            JRD:     state_nxt = IDLE;
            CRD:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // Nothing issues while a read is returning data; the CPU request
        // being consumed this cycle is not eligible again.
        can_issue    = (state_nxt == IDLE);
        arb_req_jtag = can_issue & slot_valid_nxt;
        arb_req_cpu  = can_issue & cpu.cpu_req & ~gnt_cpu_q;
    end

    fft_acc_nios2_gen2_0_cpu_ocimem_rr_arb u_arb (
        .clk      (clk),
        .reset_n  (reset_n),
        .req_jtag (arb_req_jtag),
        .req_cpu  (arb_req_cpu),
        .gnt_jtag (arb_gnt_jtag),
        .gnt_cpu  (arb_gnt_cpu)
    );

    // RAM port driven straight from the issue-cycle grant registers.
    always_comb begin
        ram_en    = gnt_jtag_q | gnt_cpu_q;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (gnt_jtag_q) begin
            ram_we    = slot_we;
            ram_addr  = slot_addr;
            ram_wdata = slot_we ? slot_wdata : '0;
        end else if (gnt_cpu_q) begin
            ram_we    = cpu.cpu_write;
            ram_addr  = cpu.cpu_addr;
            ram_wdata = cpu.cpu_write ? cpu.cpu_wdata : '0;
        end
    end

    // Sequencer FSM with registered grants and read-return outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            gnt_jtag_q   <= 1'b0;
            gnt_cpu_q    <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            MonDReg      <= '0;
        end else begin
            state        <= state_nxt;
            gnt_jtag_q   <= arb_gnt_jtag;
            gnt_cpu_q    <= arb_gnt_cpu;
            cpu_rvalid_q <= (state == CRD);
            if (state == CRD) begin
                cpu_rdata_q <= ram_rdata;
            end
            if (state == JRD) begin
                MonDReg <= ram_rdata;
            end
        end
    end

    // JTAG pending slot and address pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_valid <= 1'b0;
            slot_we    <= 1'b0;
            slot_addr  <= '0;
            slot_wdata <= '0;
            jaddr      <= '0;
            jmode_rd   <= 1'b0;
        end else begin
            slot_valid <= slot_valid_nxt;
            slot_we    <= slot_we_nxt;
            slot_addr  <= slot_addr_nxt;
            slot_wdata <= slot_wdata_nxt;
            jaddr      <= jaddr_nxt;
            jmode_rd   <= jmode_rd_nxt;
        end
    end

    // Monitor status: ready on JTAG completion, sticky error on drops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
        end else begin
            if ((state == JRD) || (gnt_jtag_q && slot_we)) begin
                monitor_ready <= 1'b1;
            end
            // A freshly accepted command starts a new operation.
            if (accept_a) begin
                monitor_ready <= 1'b0;
            end
            if (take_no_action_ocimem_a) begin
                monitor_error <= 1'b0;
            end
            if (drop) begin
                monitor_error <= 1'b1;
            end
        end
    end

endmodule
